// File: rtl/counter_10000_core.sv
// Run/stop/clear control and prescaled 0..MAX_COUNT counter feeding the FND display.
// Optional feature: define COUNT_DOWN_EN to honour the mode input (up/down counting).
module counter_10000_core #(
    parameter int TICK_DIV  = 10_000_000,
    parameter int MAX_COUNT = 9999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_run,
    input  logic        btn_clear,
    input  logic        mode,
    output logic [13:0] count,
    output logic        run,
    output logic        carry
);

    localparam int                PCNT_W    = $clog2(TICK_DIV);
    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(TICK_DIV - 1);
    localparam logic [13:0]       COUNT_MAX = 14'(MAX_COUNT);

    typedef enum logic [1:0] {
        ST_STOP,
        ST_RUN,
        ST_CLEAR
    } state_e;

    state_e              state_q, state_d;
    logic [PCNT_W-1:0]   pcnt_q, pcnt_d;
    logic [13:0]         count_q, count_d;
    logic                run_q, run_d;
    logic                carry_q, carry_d;
    logic                tick;
    logic                up_wrap;
    logic [13:0]         up_next;

    assign tick    = (state_q == ST_RUN) && (pcnt_q == PCNT_LAST);
    assign up_wrap = (count_q >= COUNT_MAX);
    assign up_next = up_wrap ? '0 : count_q + 14'd1;

`ifdef COUNT_DOWN_EN
    logic        down_wrap;
    logic [13:0] down_next;

    assign down_wrap = (count_q == '0);
    assign down_next = down_wrap ? COUNT_MAX : count_q - 14'd1;
`else
    logic unused_mode;
    assign unused_mode = mode;
`endif

    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_STOP: begin
                if (btn_clear)    state_d = ST_CLEAR;
                else if (btn_run) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (btn_run) state_d = ST_STOP;
            end
            ST_CLEAR: state_d = ST_STOP;
            default:  state_d = ST_STOP;
        endcase
    end

    // The prescaler only survives while staying in RUN; any exit drops the partial period.
    always_comb begin
        pcnt_d = '0;
        if ((state_q == ST_RUN) && (state_d == ST_RUN) && !tick) begin
            pcnt_d = pcnt_q + PCNT_W'(1);
        end
    end

    always_comb begin
        count_d = count_q;
        carry_d = 1'b0;
        if (state_q == ST_CLEAR) begin
            count_d = '0;
        end else if (tick) begin
`ifdef COUNT_DOWN_EN
            if (mode) begin
                count_d = down_next;
                carry_d = down_wrap;
            end else begin
                count_d = up_next;
                carry_d = up_wrap;
            end
`else
            count_d = up_next;
            carry_d = up_wrap;
`endif
        end
    end

    assign run_d = (state_d == ST_RUN);

    // NOTE: sequential state uses non-blocking assignments so all flops sample the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_STOP;
            pcnt_q  <= '0;
            count_q <= '0;
            run_q   <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pcnt_q  <= pcnt_d;
            count_q <= count_d;
            run_q   <= run_d;
            carry_q <= carry_d;
        end
    end

    assign count = count_q;
    assign run   = run_q;
    assign carry = carry_q;

endmodule

// File: tb/tb_counter_10000_core.sv
// Self-checking bench for counter_10000_core: vector table, directed corners and
// randomized pulses against a cycle-accurate behavioural model (TICK_DIV = 4).
module tb_counter_10000_core;

    localparam int TICK_DIV  = 4;
    localparam int MAX_COUNT = 9999;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        btn_run = 1'b0;
    logic        btn_clear = 1'b0;
    logic        mode = 1'b0;
    logic [13:0] count;
    logic        run;
    logic        carry;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    counter_10000_core #(
        .TICK_DIV (TICK_DIV),
        .MAX_COUNT(MAX_COUNT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_run  (btn_run),
        .btn_clear(btn_clear),
        .mode     (mode),
        .count    (count),
        .run      (run),
        .carry    (carry)
    );

    // Behavioural model: running flag, pending clear, cycles elapsed since RUN entry.
    bit m_running;
    bit m_clearing;
    int m_count;
    int m_elapsed;
    bit m_carry;

    typedef struct {
        bit br;
        bit bc;
        int exp_count;
        bit exp_run;
        bit exp_carry;
    } vec_t;

    vec_t vecs[25];

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic model_reset();
        m_running  = 1'b0;
        m_clearing = 1'b0;
        m_count    = 0;
        m_elapsed  = 0;
        m_carry    = 1'b0;
    endtask

    task automatic model_step(input bit br, input bit bc, input bit md);
        bit down;
`ifdef COUNT_DOWN_EN
        down = md;
`else
        down = 1'b0;
`endif
        m_carry = 1'b0;
        if (m_clearing) begin
            m_count    = 0;
            m_clearing = 1'b0;
        end else if (m_running) begin
            m_elapsed++;
            if (m_elapsed % TICK_DIV == 0) begin
                if (down) begin
                    m_carry = (m_count == 0);
                    m_count = (m_count + MAX_COUNT) % (MAX_COUNT + 1);
                end else begin
                    m_carry = (m_count == MAX_COUNT);
                    m_count = (m_count + 1) % (MAX_COUNT + 1);
                end
            end
            if (br) m_running = 1'b0;
        end else if (bc) begin
            m_clearing = 1'b1;
        end else if (br) begin
            m_running = 1'b1;
            m_elapsed = 0;
        end
    endtask

    task automatic apply(input bit br, input bit bc, input string tag);
        btn_run   = br;
        btn_clear = bc;
        @(posedge clk);
        model_step(br, bc, mode);
        #1;
        btn_run   = 1'b0;
        btn_clear = 1'b0;
        check({tag, ".count"}, int'(count), m_count);
        check({tag, ".run"},   int'(run),   int'(m_running));
        check({tag, ".carry"}, int'(carry), int'(m_carry));
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        check("reset.count", int'(count), 0);
        check("reset.run",   int'(run),   0);
        check("reset.carry", int'(carry), 0);
    endtask

    initial begin
        vecs[0] = '{br: 1'b1, bc: 1'b0, exp_count: 0, exp_run: 1'b1, exp_carry: 1'b0};
        for (int k = 1; k <= 20; k++) begin
            vecs[k] = '{br: 1'b0, bc: 1'b0, exp_count: k / TICK_DIV, exp_run: 1'b1, exp_carry: 1'b0};
        end
        vecs[21] = '{br: 1'b1, bc: 1'b0, exp_count: 5, exp_run: 1'b0, exp_carry: 1'b0};
        for (int k = 22; k < 25; k++) begin
            vecs[k] = '{br: 1'b0, bc: 1'b0, exp_count: 5, exp_run: 1'b0, exp_carry: 1'b0};
        end

        // Reset and idle
        do_reset(2);
        repeat (20) apply(1'b0, 1'b0, "idle");
        check("idle.hold0", int'(count), 0);

        // Run cadence from the vector table
        for (int i = 0; i < 25; i++) begin
            apply(vecs[i].br, vecs[i].bc, "vec");
            check($sformatf("vec%0d.count", i), int'(count), vecs[i].exp_count);
            check($sformatf("vec%0d.run", i),   int'(run),   int'(vecs[i].exp_run));
            check($sformatf("vec%0d.carry", i), int'(carry), int'(vecs[i].exp_carry));
        end

        // Clear priority: reach 37 in STOP, then run+clear together
        apply(1'b1, 1'b0, "to37");
        repeat (128) apply(1'b0, 1'b0, "to37");
        apply(1'b1, 1'b0, "to37");
        check("stop37.count", int'(count), 37);
        check("stop37.run",   int'(run),   0);
        apply(1'b1, 1'b1, "both");
        check("both.run", int'(run), 0);
        apply(1'b0, 1'b0, "clear");
        check("clear.count", int'(count), 0);
        check("clear.run",   int'(run),   0);
        apply(1'b0, 1'b0, "clear_after");
        check("clear_after.run", int'(run), 0);

        // Clear ignored in RUN
        apply(1'b1, 1'b0, "runclr");
        repeat (5) apply(1'b0, 1'b0, "runclr");
        apply(1'b0, 1'b1, "runclr");
        check("runclr.count", int'(count), 1);
        check("runclr.run",   int'(run),   1);
        repeat (3) apply(1'b0, 1'b0, "runclr");
        apply(1'b1, 1'b0, "runclr_stop");

        // btn_run during the CLEAR cycle is lost
        apply(1'b0, 1'b1, "lost");
        apply(1'b1, 1'b0, "lost");
        check("lost.run",   int'(run),   0);
        check("lost.count", int'(count), 0);
        apply(1'b0, 1'b0, "lost_after");
        check("lost_after.run", int'(run), 0);

        // Randomized pulses and mode changes against the model
        for (int i = 0; i < 3000; i++) begin
            int r;
            bit br;
            bit bc;
            r  = int'($urandom_range(0, 99));
            br = (r < 4) || (r == 9);
            bc = (r >= 5 && r < 8) || (r == 9);
            if ($urandom_range(0, 49) == 0) mode = ~mode;
            apply(br, bc, "rand");
        end

        // Reset mid-run at count 123, pcnt 2
        mode = 1'b0;
        do_reset(2);
        apply(1'b1, 1'b0, "to123");
        repeat (123 * TICK_DIV) apply(1'b0, 1'b0, "to123");
        check("mid.count123", int'(count), 123);
        repeat (2) apply(1'b0, 1'b0, "mid");
        do_reset(1);
        repeat (8) apply(1'b0, 1'b0, "post_rst");
        check("post_rst.count", int'(count), 0);
        check("post_rst.run",   int'(run),   0);

        // Up wrap 9998 -> 9999 -> 0 with one-cycle carry
        do_reset(2);
        apply(1'b1, 1'b0, "wrap");
        repeat (9998 * TICK_DIV) apply(1'b0, 1'b0, "wrap");
        check("wrap.9998", int'(count), 9998);
        repeat (TICK_DIV) apply(1'b0, 1'b0, "wrap");
        check("wrap.9999", int'(count), 9999);
        check("wrap.9999.carry", int'(carry), 0);
        repeat (TICK_DIV) apply(1'b0, 1'b0, "wrap");
        check("wrap.zero",  int'(count), 0);
        check("wrap.carry", int'(carry), 1);
        apply(1'b0, 1'b0, "wrap_after");
        check("wrap_after.carry", int'(carry), 0);

        // Down mode from zero
        do_reset(2);
        mode = 1'b1;
        apply(1'b1, 1'b0, "down");
        repeat (TICK_DIV) apply(1'b0, 1'b0, "down");
`ifdef COUNT_DOWN_EN
        check("down.count", int'(count), MAX_COUNT);
        check("down.carry", int'(carry), 1);
`else
        check("down_ignored.count", int'(count), 1);
        check("down_ignored.carry", int'(carry), 0);
`endif
        apply(1'b0, 1'b0, "down_after");
        check("down_after.carry", int'(carry), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
